game_flow_ctrl: RTL and testbench

- Top-level game sequencer directly upstream of playController.
- Owns game_status (CHOSE_BOARD / GAME_INITIAL / GAMING / WINNED) and supplies origin_bd from an internal board ROM.
- Consumes playController's win_flag and the same one-hot act pulses, plus confirm/quit pulses from the button stage.
- Counts player moves for display.

---
 rtl/game_pkg.sv | 20 ++
 rtl/game_flow_ctrl_board_rom.sv | 20 ++
 rtl/game_flow_ctrl.sv | 104 ++++++++++
 tb/tb_game_flow_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: status encodings, board geometry
// and act bus bit positions common to game_flow_ctrl and playController.
package game_pkg;

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } status_t;

  localparam int CELL_W  = 3;
  localparam int BOARD_W = 4 * CELL_W;

  localparam int ACT_UP    = 0;
  localparam int ACT_DOWN  = 1;
  localparam int ACT_LEFT  = 2;
  localparam int ACT_RIGHT = 3;

endpackage

// File: rtl/game_flow_ctrl_board_rom.sv
// Starting-board table; indices beyond the four stored boards alias modulo 4.
module board_rom
  import game_pkg::*;
(
  input  logic [2:0]         idx,
  output logic [BOARD_W-1:0] board
);

  always_comb begin
    board = 12'b001_011_000_010;
    case (idx)
      3'd0, 3'd4: board = 12'b001_011_000_010;
      3'd1, 3'd5: board = 12'b011_010_001_000;
      3'd2, 3'd6: board = 12'b000_001_011_010;
      3'd3, 3'd7: board = 12'b010_000_011_001;
      default:    board = 12'b001_011_000_010;
    endcase
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: board selection, load window, move counting and win hold,
// feeding game_status and origin_bd to playController.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_BOARDS  = 4,
  parameter int INIT_CYCLES = 4,
  parameter int WIN_HOLD    = 100_000_000,
  parameter int MOVE_W      = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         act,
  input  logic               confirm,
  input  logic               quit,
  input  logic               win_flag,
  output logic [1:0]         game_status,
  output logic [BOARD_W-1:0] origin_bd,
  output logic [2:0]         board_idx,
  output logic [MOVE_W-1:0]  move_cnt
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int HOLD_W = $clog2(WIN_HOLD);

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WIN_HOLD - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(NUM_BOARDS - 1);
  localparam logic [3:0]        ACT_NEXT  = 4'b0001 << ACT_UP;
  localparam logic [3:0]        ACT_PREV  = 4'b0001 << ACT_DOWN;

  status_t             status_reg;
  logic [2:0]          board_idx_reg;
  logic [MOVE_W-1:0]   move_cnt_reg;
  logic [INIT_W-1:0]   init_cnt_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [2:0]          idx_inc;
  logic [2:0]          idx_dec;

  assign idx_inc = (board_idx_reg == IDX_LAST) ? 3'd0 : board_idx_reg + 3'd1;
  assign idx_dec = (board_idx_reg == 3'd0) ? IDX_LAST : board_idx_reg - 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_reg    <= CHOSE_BOARD;
      board_idx_reg <= 3'd0;
      move_cnt_reg  <= '0;
      init_cnt_reg  <= '0;
      hold_cnt_reg  <= '0;
    end else begin
      case (status_reg)
        CHOSE_BOARD: begin
          if (confirm) begin
            status_reg   <= GAME_INITIAL;
            move_cnt_reg <= '0;
            init_cnt_reg <= '0;
          end else if (act == ACT_NEXT) begin
            board_idx_reg <= idx_inc;
          end else if (act == ACT_PREV) begin
            board_idx_reg <= idx_dec;
          end
        end
        GAME_INITIAL: begin
          if (init_cnt_reg == INIT_LAST) begin
            status_reg <= GAMING;
          end else begin
            init_cnt_reg <= init_cnt_reg + 1'b1;
          end
        end
        GAMING: begin
          // A move landing on the winning cycle still counts.
          if ((|act) && (move_cnt_reg != '1)) begin
            move_cnt_reg <= move_cnt_reg + 1'b1;
          end
          if (win_flag) begin
            status_reg   <= WINNED;
            hold_cnt_reg <= '0;
          end else if (quit) begin
            status_reg <= CHOSE_BOARD;
          end
        end
        WINNED: begin
          if (confirm || (hold_cnt_reg == HOLD_LAST)) begin
            status_reg    <= CHOSE_BOARD;
            board_idx_reg <= idx_inc;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: status_reg <= CHOSE_BOARD;
      endcase
    end
  end

  assign game_status = status_reg;
  assign board_idx   = board_idx_reg;
  assign move_cnt    = move_cnt_reg;

  board_rom u_board_rom (
    .idx   (board_idx_reg),
    .board (origin_bd)
  );

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short load window and win hold.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam logic [11:0] ROM0 = 12'b001_011_000_010;
  localparam logic [11:0] ROM2 = 12'b000_001_011_010;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  act = 4'b0;
  logic        confirm = 1'b0;
  logic        quit = 1'b0;
  logic        win_flag = 1'b0;
  logic [1:0]  game_status;
  logic [11:0] origin_bd;
  logic [2:0]  board_idx;
  logic [9:0]  move_cnt;

  int n_vec = 0;
  int n_err = 0;

  game_flow_ctrl #(
    .NUM_BOARDS  (4),
    .INIT_CYCLES (2),
    .WIN_HOLD    (8),
    .MOVE_W      (10)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .act         (act),
    .confirm     (confirm),
    .quit        (quit),
    .win_flag    (win_flag),
    .game_status (game_status),
    .origin_bd   (origin_bd),
    .board_idx   (board_idx),
    .move_cnt    (move_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] a, input logic c, input logic q, input logic w,
                       input bit quiet = 1'b0);
    act = a; confirm = c; quit = q; win_flag = w;
    @(posedge clk);
    #1;
    act = 4'b0; confirm = 1'b0; quit = 1'b0; win_flag = 1'b0;
    if (!quiet)
      $display("txn act=%b confirm=%b quit=%b win=%b -> status=%b idx=%0d moves=%0d",
               a, c, q, w, game_status, board_idx, move_cnt);
  endtask

  task automatic step();
    pulse(4'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_state(input string tag, input status_t st, input logic [2:0] idx,
                              input logic [9:0] mv);
    check({tag, ".status"}, 32'(game_status), 32'(st));
    check({tag, ".idx"},    32'(board_idx),   32'(idx));
    check({tag, ".moves"},  32'(move_cnt),    32'(mv));
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #12;
    expect_state("reset", CHOSE_BOARD, 3'd0, 10'd0);
    check("reset.origin", 32'(origin_bd), 32'(ROM0));
    release_reset();

    // Board selection with wrap in both directions
    pulse(4'b0001, 0, 0, 0); check("sel1.idx", 32'(board_idx), 32'd1);
    pulse(4'b0001, 0, 0, 0); check("sel2.idx", 32'(board_idx), 32'd2);
    check("sel2.origin", 32'(origin_bd), 32'(ROM2));
    pulse(4'b0001, 0, 0, 0); check("sel3.idx", 32'(board_idx), 32'd3);
    pulse(4'b0010, 0, 0, 0); check("sel4.idx", 32'(board_idx), 32'd2);
    pulse(4'b0011, 0, 1, 0); check("sel_multi.idx", 32'(board_idx), 32'd2);
    check("sel_quit.status", 32'(game_status), 32'(CHOSE_BOARD));
    pulse(4'b0001, 0, 0, 0);
    pulse(4'b0001, 0, 0, 0); check("wrap_up.idx", 32'(board_idx), 32'd0);
    check("wrap_up.origin", 32'(origin_bd), 32'(ROM0));
    pulse(4'b0010, 0, 0, 0); check("wrap_dn.idx", 32'(board_idx), 32'd3);
    pulse(4'b0001, 0, 0, 0); check("wrap_back.idx", 32'(board_idx), 32'd0);

    // Load window: two cycles of GAME_INITIAL, inputs ignored
    pulse(4'b0, 1, 0, 0);
    expect_state("init1", GAME_INITIAL, 3'd0, 10'd0);
    pulse(4'b0001, 1, 1, 1);
    expect_state("init2", GAME_INITIAL, 3'd0, 10'd0);
    step();
    expect_state("gaming", GAMING, 3'd0, 10'd0);

    // Move counting
    pulse(4'b0001, 0, 0, 0);
    pulse(4'b0010, 0, 0, 0);
    pulse(4'b0100, 0, 0, 0);
    pulse(4'b1000, 0, 0, 0);
    pulse(4'b0100, 0, 0, 0);
    pulse(4'b0011, 0, 0, 0);
    check("moves6", 32'(move_cnt), 32'd6);
    step(); check("idle.moves", 32'(move_cnt), 32'd6);
    pulse(4'b0, 1, 0, 0);
    check("confirm_ign.status", 32'(game_status), 32'(GAMING));
    for (int i = 0; i < 1017; i++) pulse(4'b0001, 0, 0, 0, 1'b1);
    check("moves_max", 32'(move_cnt), 32'd1023);
    pulse(4'b1000, 0, 0, 0);
    check("moves_sat", 32'(move_cnt), 32'd1023);

    // Quit keeps index and count; confirm beats act
    pulse(4'b0, 0, 1, 0);
    expect_state("quit", CHOSE_BOARD, 3'd0, 10'd1023);
    pulse(4'b0001, 1, 0, 0);
    expect_state("confirm_act", GAME_INITIAL, 3'd0, 10'd0);
    step(); step();
    check("gaming2.status", 32'(game_status), 32'(GAMING));

    // Win beats quit, same-cycle move counted, timed exit after 8 cycles
    pulse(4'b0001, 0, 0, 0);
    pulse(4'b0001, 0, 1, 1);
    expect_state("win", WINNED, 3'd0, 10'd2);
    for (int i = 0; i < 7; i++) pulse(4'b0010, 0, 1, 0);
    expect_state("hold_last", WINNED, 3'd0, 10'd2);
    step();
    expect_state("hold_exit", CHOSE_BOARD, 3'd1, 10'd2);
    pulse(4'b0001, 0, 0, 0);
    expect_state("frozen", CHOSE_BOARD, 3'd2, 10'd2);

    // Confirm exit from WINNED, including index wrap
    pulse(4'b0, 1, 0, 0); step(); step();
    pulse(4'b0, 0, 0, 1); step(); step();
    pulse(4'b0, 1, 0, 0);
    expect_state("conf_exit", CHOSE_BOARD, 3'd3, 10'd0);
    pulse(4'b0, 1, 0, 0); step(); step();
    pulse(4'b0, 0, 0, 1);
    pulse(4'b0, 1, 0, 0);
    expect_state("conf_wrap", CHOSE_BOARD, 3'd0, 10'd0);

    // Asynchronous reset mid-GAME_INITIAL
    pulse(4'b0001, 0, 0, 0);
    pulse(4'b0, 1, 0, 0);
    check("pre_rst1.status", 32'(game_status), 32'(GAME_INITIAL));
    #3 reset_n = 1'b0;
    #1;
    expect_state("rst_init", CHOSE_BOARD, 3'd0, 10'd0);
    release_reset();

    // Asynchronous reset mid-WINNED
    pulse(4'b0001, 0, 0, 0);
    pulse(4'b0, 1, 0, 0); step(); step();
    pulse(4'b0001, 0, 0, 0);
    pulse(4'b0, 0, 0, 1); step();
    expect_state("pre_rst2", WINNED, 3'd1, 10'd1);
    #3 reset_n = 1'b0;
    #1;
    expect_state("rst_win", CHOSE_BOARD, 3'd0, 10'd0);
    check("rst_win.origin", 32'(origin_bd), 32'(ROM0));
    release_reset();
    step();
    check("post_rst.status", 32'(game_status), 32'(CHOSE_BOARD));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
